// File: rtl/print_pkg.sv
// ---------------------------------------------------------------------------
// print_pkg
// Shared definitions for the DekatronPC print buffer: the ASCII control
// characters the output stage cares about, the output FSM state type and
// the default FIFO depth.
// ---------------------------------------------------------------------------
package print_pkg;

   localparam logic [6:0] ASCII_LF    = 7'h0A;
   localparam logic [6:0] ASCII_CR    = 7'h0D;
   localparam int         PRINT_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHAR,
      ST_CR
   } print_state_e;

endpackage

// File: rtl/print_fifo_ram.sv
// ---------------------------------------------------------------------------
// print_fifo_ram
// Simple dual-port character storage for the print buffer: one synchronous
// write port and one asynchronous read port, DEPTH x DATA_WIDTH. Pointers
// and flags live in the parent; this block is storage only.
//
// Ports:
//   clk      - buffer clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module print_fifo_ram #(
   parameter int DATA_WIDTH = 7,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Storage array is deliberately left without reset so it maps onto
   // distributed RAM; the parent's pointers decide which entries are valid.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/print_buffer.sv
// ---------------------------------------------------------------------------
// print_buffer
// Elastic character buffer between the DekatronPC print path and the serial
// printer transmitter. Characters are queued in a circular FIFO and handed
// to the transmitter through a registered output stage. The FIFO fill level
// is exported for the front-panel display.
//
// Optional feature macro: PRINT_CRLF_EN
//   defined   - every LF leaving the FIFO is preceded by a CR
//   undefined - characters pass unmodified; CR state and holding register
//               are not built
//
// Ports:
//   clk      - 1 MHz system clock
//   rst      - asynchronous active-high reset
//   flush_i  - synchronous clear of FIFO and output stage
//   i_vld    - upstream character valid
//   i_data   - upstream character
//   o_rdy    - buffer can accept (not full)
//   tx_vld   - character presented to transmitter
//   tx_data  - character presented to transmitter
//   tx_rdy   - transmitter accepts
//   level_o  - FIFO entries held, excluding the output register
// ---------------------------------------------------------------------------
module print_buffer
   import print_pkg::*;
#(
   parameter int DATA_WIDTH = 7,
   parameter int DEPTH      = PRINT_DEPTH,
   parameter int LEVEL_W    = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_rdy,
   output logic                  tx_vld,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_rdy,
   output logic [LEVEL_W-1:0]    level_o
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   localparam logic [DATA_WIDTH-1:0] CHAR_LF = DATA_WIDTH'(ASCII_LF);
   localparam logic [DATA_WIDTH-1:0] CHAR_CR = DATA_WIDTH'(ASCII_CR);

   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   print_state_e          r_state;
   print_state_e          w_stateNext;
   logic                  r_txVld;
   logic [DATA_WIDTH-1:0] r_txData;
   logic [DATA_WIDTH-1:0] w_txDataNext;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_loadHead;
`ifdef PRINT_CRLF_EN
   logic [DATA_WIDTH-1:0] r_heldChar;
   logic [DATA_WIDTH-1:0] w_heldNext;
`endif

   // Extra pointer MSB distinguishes full from empty when the address bits match.
   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_full  = (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]) &&
                    (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]);

   assign o_rdy   = ~w_full;
   assign w_push  = i_vld & ~w_full & ~flush_i;
   assign level_o = LEVEL_W'(r_wrPtr - r_rdPtr);
   assign tx_vld  = r_txVld;
   assign tx_data = r_txData;

   print_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wrPtr[ADDR_W-1:0]),
      .i_wdata (i_data),
      .i_raddr (r_rdPtr[ADDR_W-1:0]),
      .o_rdata (w_head)
   );

   // Output stage next-state logic. A head load happens from IDLE whenever
   // the FIFO has data, and from CHAR right on the accepting cycle so the
   // transmitter sees back-to-back characters. The CR state replays the
   // held LF without touching the FIFO.
   always_comb begin
      w_stateNext  = r_state;
      w_txDataNext = r_txData;
      w_loadHead   = 1'b0;
      w_pop        = 1'b0;
`ifdef PRINT_CRLF_EN
      w_heldNext   = r_heldChar;
`endif
      case (r_state)
         ST_IDLE: begin
            w_loadHead = ~w_empty;
         end
         ST_CHAR: begin
            if (tx_rdy) begin
               if (!w_empty) begin
                  w_loadHead = 1'b1;
               end else begin
                  w_stateNext = ST_IDLE;
               end
            end
         end
`ifdef PRINT_CRLF_EN
         ST_CR: begin
            if (tx_rdy) begin
               w_txDataNext = r_heldChar;
               w_stateNext  = ST_CHAR;
            end
         end
`endif
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase

      if (w_loadHead) begin
         w_pop = 1'b1;
`ifdef PRINT_CRLF_EN
         if (w_head == CHAR_LF) begin
            w_txDataNext = CHAR_CR;
            w_heldNext   = w_head;
            w_stateNext  = ST_CR;
         end else begin
            w_txDataNext = w_head;
            w_stateNext  = ST_CHAR;
         end
`else
         w_txDataNext = w_head;
         w_stateNext  = ST_CHAR;
`endif
      end
   end

   // Pointer, state and output registers. Flush equalises the pointers by
   // pulling the read pointer up to the write pointer and discards any
   // push or pop requested in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_state  <= ST_IDLE;
         r_txVld  <= 1'b0;
         r_txData <= '0;
      end else if (flush_i) begin
         r_rdPtr  <= r_wrPtr;
         r_state  <= ST_IDLE;
         r_txVld  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         r_state  <= w_stateNext;
         r_txVld  <= (w_stateNext != ST_IDLE);
         r_txData <= w_txDataNext;
      end
   end

`ifdef PRINT_CRLF_EN
   // Holds the LF that follows an inserted CR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_heldChar <= '0;
      end else begin
         r_heldChar <= w_heldNext;
      end
   end
`endif

endmodule
